// File: rtl/muldiv_sequencer.sv
// Purpose: iterative MIPS-style multiply/divide sequencer that owns the HI/LO pair.
// Latency: MTHI/MTLO write at the start edge; MULT(U)/DIV(U) write HI/LO 33 edges after start, done the cycle after.
// Backpressure: none internally; start is ignored while busy, so the decoder must stall on busy.
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-low reset
//   start, op        request strobe and op code (000 MTHI, 001 MTLO, 010 MULTU, 011 DIVU, 100 MULT, 101 DIV)
//   in_1, in_2       rs / rt operands
//   cancel           pipeline flush; aborts an in-flight op and blocks a same-edge start
//   busy, done       op in flight / one-cycle completion pulse
//   hi, lo           HI and LO architectural registers
// Optional: define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int ITERS = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] in_1,
  input  logic [31:0] in_2,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MTHI  = 3'b000;
  localparam logic [2:0] OP_MTLO  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MULT  = 3'b100;
  localparam logic [2:0] OP_DIV   = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      acc;       // running product
  logic [63:0]      mcand;     // multiplicand, shifted left one place per iteration
  logic [31:0]      mplier;    // multiplier, consumed LSB first
  logic [31:0]      rem;       // partial remainder
  logic [31:0]      quot;      // dividend shifts out the top while quotient bits shift in
  logic [31:0]      dvs;       // divisor magnitude
  logic             neg_res;   // product / quotient must be negated
  logic             neg_rem;   // remainder takes the dividend's sign
  logic             is_div;
  logic             div_zero;

  logic        is_mul_op, is_div_op, signed_op;
  logic [31:0] mag_1, mag_2;
  logic        iter_last, mul_last;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] rem_step;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign is_mul_op = (op == OP_MULTU) || (op == OP_MULT);
  assign is_div_op = (op == OP_DIVU)  || (op == OP_DIV);
  assign signed_op = (op == OP_MULT)  || (op == OP_DIV);
  assign mag_1     = (signed_op && in_1[31]) ? -in_1 : in_1;
  assign mag_2     = (signed_op && in_2[31]) ? -in_2 : in_2;

  assign iter_last = (cnt == CNT_W'(ITERS - 1));

`ifdef MULDIV_EARLY_OUT_EN
  // Bit 0 is consumed this cycle; if nothing remains above it the product is complete.
  assign mul_last = (mplier[31:1] == '0) || iter_last;
`else
  assign mul_last = iter_last;
`endif

  // Restoring step: div_shift[32] is the guard bit, so the compare sees the full 33-bit value
  // while the difference (taken only when it cannot go negative) always fits in 32 bits.
  assign div_shift = {rem, quot[31]};
  assign div_ge    = (div_shift >= {1'b0, dvs});
  assign rem_step  = div_ge ? (div_shift[31:0] - dvs) : div_shift[31:0];

  assign prod_fix = neg_res ? -acc  : acc;
  assign quot_fix = neg_res ? -quot : quot;
  assign rem_fix  = neg_rem ? -rem  : rem;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          if (is_mul_op)      state_nxt = MUL;
          else if (is_div_op) state_nxt = DIV;
        end
      end
      MUL: begin
        if (cancel)        state_nxt = IDLE;
        else if (mul_last) state_nxt = FIX;
      end
      DIV: begin
        if (cancel)         state_nxt = IDLE;
        else if (iter_last) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quot     <= '0;
      dvs      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MTHI: hi <= in_1;
              OP_MTLO: lo <= in_2;
              OP_MULTU, OP_MULT: begin
                acc     <= '0;
                mcand   <= {32'd0, mag_1};
                mplier  <= mag_2;
                neg_res <= signed_op && (in_1[31] ^ in_2[31]);
                neg_rem <= 1'b0;
                is_div  <= 1'b0;
                cnt     <= '0;
              end
              OP_DIVU, OP_DIV: begin
                rem      <= '0;
                quot     <= mag_1;
                dvs      <= mag_2;
                neg_res  <= signed_op && (in_1[31] ^ in_2[31]);
                neg_rem  <= signed_op && in_1[31];
                div_zero <= (in_2 == 32'd0);
                is_div   <= 1'b1;
                cnt      <= '0;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        DIV: begin
          rem  <= rem_step;
          quot <= {quot[30:0], div_ge};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              // A zero divisor leaves all-ones in the quotient and the dividend magnitude in rem;
              // re-signing rem restores in_1 exactly, but the quotient is forced to all ones.
              lo <= div_zero ? 32'hFFFF_FFFF : quot_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam logic [2:0] OP_MTHI  = 3'b000;
  localparam logic [2:0] OP_MTLO  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MULT  = 3'b100;
  localparam logic [2:0] OP_DIV   = 3'b101;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in_1, in_2;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in_1(in_1), .in_2(in_2),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one op, straight from the instruction semantics.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] ohi, input logic [31:0] olo,
                                    output logic [31:0] nhi, output logic [31:0] nlo);
    longint sa, sb, q, r, p;
    logic [63:0] up;
    nhi = ohi;
    nlo = olo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MTHI: nhi = a;
      OP_MTLO: nlo = b;
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {nhi, nlo} = up;
      end
      OP_MULT: begin
        p = sa * sb;
        {nhi, nlo} = p;
      end
      OP_DIVU: begin
        if (b == 0) begin nhi = a; nlo = 32'hFFFF_FFFF; end
        else begin nlo = a / b; nhi = a % b; end
      end
      OP_DIV: begin
        if (b == 0) begin nhi = a; nlo = 32'hFFFF_FFFF; end
        else begin
          q = sa / sb;
          r = sa % sb;
          nlo = 32'(q);
          nhi = 32'(r);
        end
      end
      default: ;
    endcase
  endfunction

  function automatic int exp_iters(input logic [2:0] o, input logic [31:0] b);
    logic [31:0] mag;
    int eo;
    mag = (o == OP_MULT && b[31]) ? -b : b;
    eo = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) eo = i + 1;
    if (EARLY_OUT && (o == OP_MULTU || o == OP_MULT)) return eo;
    return 32;
  endfunction

  // Issue one op and follow it to completion. poke >= 0 pulses a stray start that many edges in.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int poke, input string tag);
    int n, nbusy, want;
    bit held;
    start = 1'b1; op = o; in_1 = a; in_2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("%s_done_low", tag), done, 0);
    if (o == OP_MULTU || o == OP_MULT || o == OP_DIVU || o == OP_DIV) begin
      want = exp_iters(o, b);
      n = 0; nbusy = 0; held = 1'b1;
      while (!done && n < 200) begin
        if (busy) nbusy++;
        if (hi !== m_hi || lo !== m_lo) held = 1'b0;
        start = (n == poke);
        if (n == poke) begin op = OP_DIVU; in_1 = 32'd100; in_2 = 32'd7; end
        @(posedge clk); #1;
        n++;
      end
      start = 1'b0;
      chk($sformatf("%s_latency", tag), n, want + 1);
      chk($sformatf("%s_busy_cycles", tag), nbusy, want + 1);
      chk($sformatf("%s_hold_old", tag), held, 1);
      chk($sformatf("%s_busy_end", tag), busy, 0);
    end else begin
      chk($sformatf("%s_busy_low", tag), busy, 0);
    end
    chk($sformatf("%s_hi", tag), hi, ehi);
    chk($sformatf("%s_lo", tag), lo, elo);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b, eh, el;
    bit          seen;

    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; in_1 = '0; in_2 = '0;
    m_hi = '0; m_lo = '0;

    vecs[0]  = '{OP_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1]  = '{OP_MTLO,  32'h0,        32'h12345678, 32'hDEADBEEF, 32'h12345678};
    vecs[2]  = '{3'b110,   32'h1,        32'h2,        32'hDEADBEEF, 32'h12345678};
    vecs[3]  = '{3'b111,   32'h3,        32'h4,        32'hDEADBEEF, 32'h12345678};
    vecs[4]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[5]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    vecs[9]  = '{OP_DIVU,  32'd9,        32'd4,        32'd1,        32'd2};
    vecs[10] = '{OP_MULTU, 32'd3,        32'd5,        32'd0,        32'd15};
    vecs[11] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[12] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[13] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    vecs[14] = '{OP_MULT,  32'd7,        32'd0,        32'd0,        32'd0};

    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, -1, $sformatf("vec%0d", i));

    // cancel in IDLE wins over start
    start = 1'b1; cancel = 1'b1; op = OP_MTHI; in_1 = 32'h11111111;
    @(posedge clk); #1;
    chk("idle_cancel_mthi_hi", hi, m_hi);
    op = OP_MULTU; in_1 = 32'd6; in_2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("idle_cancel_mul_busy", busy, 0);
    chk("idle_cancel_done", done, 0);

    // DIVU 9/4 cancelled at cycle 10
    start = 1'b1; op = OP_DIVU; in_1 = 32'd9; in_2 = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("cancel_busy_before", busy, 1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy_drop", busy, 0);
    seen = (done === 1'b1);
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    chk("cancel_no_done", seen, 0);
    chk("cancel_hi_kept", hi, m_hi);
    chk("cancel_lo_kept", lo, m_lo);

    // stray start mid-multiply must be ignored
    run_op(OP_MULTU, 32'h1234, 32'h10, 32'h0, 32'h12340, 2, "poke_mul");
    run_op(OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 5, "poke_div");

    // asynchronous reset in the middle of a multiply
    run_op(OP_MTHI, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, m_lo, -1, "pre_rst");
    start = 1'b1; op = OP_MULTU; in_1 = 32'hFFFFFFFF; in_2 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    chk("postrst_busy", busy, 0);

    // randomized back-to-back ops against the reference model
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 15));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      ref_model(o, a, b, m_hi, m_lo, eh, el);
      run_op(o, a, b, eh, el, -1, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and owner of the HI/LO register pair for the CPU's multiply/divide unit.
- Accepts one op per request from the decode/execute stage and runs signed or unsigned multiply/divide iteratively over 32 cycles.
- Handles MTHI/MTLO in one cycle and drives busy/done so the pipeline can stall MFHI/MFLO and back-to-back ops.

Parameters:
- ITERS, 32, number of iteration cycles for multiply and divide; equals operand width and must stay 32.
- CNT_W, 6, width of the iteration counter; must be at least clog2(ITERS)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe, sampled on the rising edge.
- op  input  3  000 MTHI, 001 MTLO, 010 MULTU, 011 DIVU, 100 MULT, 101 DIV; 110/111 reserved.
- in_1  input  32  rs operand: dividend, multiplicand, or MTHI data.
- in_2  input  32  rt operand: divisor, multiplier, or MTLO data.
- cancel  input  1  pipeline flush; aborts the in-flight op.
- busy  output  1  high while an iterative op is in flight.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0.
  - State IDLE, counter 0, internal accumulators 0.
  - Reset asserted mid-op discards the op immediately.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, cancel=0:
  - MTHI: hi<=in_1 at that edge. No busy, no done.
  - MTLO: lo<=in_2 at that edge. No busy, no done.
  - MULTU/MULT: latch magnitudes. Signed ops take the absolute value of each operand and record the result sign (negative when the operand signs differ). Go to MUL with counter=0.
  - DIVU/DIV: latch magnitudes. Record the quotient sign (signs differ) and the remainder sign (sign of in_1). Go to DIV.
  - Reserved op codes: ignored, state unchanged.
- MUL:
  - Radix-2 shift-add over a 64-bit product register, one multiplier bit (LSB first) per cycle.
  - Counter increments each cycle; after ITERS iterations go to FIX.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - 32-bit remainder register plus a 1-bit guard; compare and subtract each cycle.
  - After ITERS iterations go to FIX.
- FIX (one cycle):
  - Apply the two's-complement sign correction, 32-bit wrap.
  - Multiply: {hi,lo}<=signed product.
  - Divide: lo<=quotient, hi<=remainder.
  - Return to IDLE; done=1 in the following cycle.
- Latency: start edge E0; busy high from after E0 until E(ITERS+1); HI/LO written at E(ITERS+1)=E33; done high for the cycle after E33.
- Arithmetic boundary cases:
  - Divide by zero (signed or unsigned): lo=32'hFFFFFFFF, hi=in_1 as presented. Normal latency, no exception.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap).
- start while busy: ignored; the decoder must stall on busy. HI/LO hold their old values until E33, and reads during busy return old values.
- cancel:
  - While busy: return to IDLE at the next edge. HI/LO unchanged, no done, busy drops.
  - In IDLE: blocks start on the same edge (cancel wins).
- start in the same cycle done is high: accepted normally. That allows back-to-back ops with zero bubble.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined: in MUL, the op proceeds to FIX as soon as the remaining unshifted multiplier magnitude is zero, with a minimum of 1 iteration. Latency is then (index of the highest set bit of |in_2|)+1 iterations, plus FIX; a zero multiplier takes 1 iteration. DIV is unaffected.
- When undefined: always ITERS iterations; fixed 33-cycle result latency.

Test Plan:
- Reset, then MTHI in_1=0xDEADBEEF, then MTLO in_2=0x12345678 -> hi=0xDEADBEEF, lo=0x12345678 one edge after each; busy and done never set.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy for 33 cycles; done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 9/4 with cancel at cycle 10 -> busy drops the next edge, no done, hi/lo keep prior values. A start issued mid-op is ignored.
- Reset pulsed low mid-MULTU -> all outputs 0 immediately. With MULDIV_EARLY_OUT_EN, MULTU 3*5 -> done after 3 iterations+FIX, lo=15.
